// File: rtl/transceiver_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : transceiver_scheduler
// Purpose  : Queues uart_rx bytes and runs each one through the codec
//            pipeline. It then gates the BPSK burst and hands the decoded byte
//            to uart_tx. The drop counter is built only with TRX_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module transceiver_scheduler #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PIPE_LAT   = 2,
    parameter int BURST_CLKS = 256,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv,
    input  logic [DATA_WIDTH-1:0] rx_byte,
    output logic [DATA_WIDTH-1:0] enc_data,
    input  logic [DATA_WIDTH-1:0] dec_data,
    input  logic                  tx_active,
    input  logic                  tx_done,
    output logic                  tx_dv,
    output logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  mod_en,
    output logic                  busy,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_cnt_w   = $clog2(DEPTH + 1);
    localparam int c_pipe_w  = $clog2(PIPE_LAT + 1);
    localparam int c_burst_w = $clog2(BURST_CLKS + 1);
    localparam logic [c_cnt_w-1:0]   c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_pipe_w-1:0]  c_pipe_last = c_pipe_w'(PIPE_LAT - 1);
    localparam logic [c_burst_w-1:0] c_burst_max = c_burst_w'(BURST_CLKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CODEC = 2'd1,
        S_ISSUE = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic [c_pipe_w-1:0]     r_pipe_cnt;
    logic [c_burst_w-1:0]    r_burst_cnt;
    logic                    r_done;
    logic [DATA_WIDTH-1:0]   r_enc_data;
    logic [DATA_WIDTH-1:0]   r_tx_byte;
    logic                    r_tx_dv;
    logic                    r_mod_en;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push;
    logic [c_burst_w-1:0]    w_burst_next;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    assign w_push  = rx_dv && (!w_full || w_pop);
    assign w_burst_next = (r_burst_cnt < c_burst_max) ? r_burst_cnt + 1'b1 : r_burst_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_enc_data  <= '0;
            r_tx_byte   <= '0;
            r_tx_dv     <= 1'b0;
            r_mod_en    <= 1'b0;
            r_pipe_cnt  <= '0;
            r_burst_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_tx_dv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_enc_data <= r_mem[r_rd_ptr];
                        r_pipe_cnt <= '0;
                        r_state    <= S_CODEC;
                    end
                end
                S_CODEC: begin
                    if (r_pipe_cnt == c_pipe_last) begin
                        r_tx_byte <= dec_data;
                        r_state   <= S_ISSUE;
                    end else begin
                        r_pipe_cnt <= r_pipe_cnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!tx_active) begin
                        r_tx_dv     <= 1'b1;
                        r_mod_en    <= 1'b1;
                        r_burst_cnt <= '0;
                        r_done      <= 1'b0;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_done) r_done <= 1'b1;
                    r_burst_cnt <= w_burst_next;
                    r_mod_en    <= (w_burst_next < c_burst_max);
                    // A done pulse landing on the final burst edge still counts.
                    if ((w_burst_next == c_burst_max) && (r_done || tx_done)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TRX_DROP_CNT_EN
    logic                 w_drop;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    assign w_drop = rx_dv && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

    assign enc_data   = r_enc_data;
    assign tx_byte    = r_tx_byte;
    assign tx_dv      = r_tx_dv;
    assign mod_en     = r_mod_en;
    assign busy       = (r_state != S_IDLE);
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;

endmodule
`default_nettype wire
